// File: rtl/dice_display.sv
// -----------------------------------------------------------------------------
// dice_display
// Registered seven-segment driver for NUM_DICE dice. Latches die values and
// shows them as active-low segment codes, plays a cycling "rolling" animation
// while a roll is in progress and (optionally) blinks the latched result a
// fixed number of times. Every update is qualified by the clock_en tick;
// reset is synchronous, active-high and overrides clock_en.
//
// Optional feature macro: DISPLAY_BLINK_EN
//   defined   -> BLINK state, blink counters and flash handling present
//   undefined -> flash ignored, SHOW leaves only on rolling
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   clock_en  in   tick qualifier
//   rolling   in   level, roll in progress
//   load      in   latch dice on this tick
//   flash     in   start a blink sequence
//   dice      in   3*NUM_DICE, die k at [3k+2:3k]
//   HEX       out  7*NUM_DICE, digit k at [7k+6:7k], active-low, registered
//   busy      out  high in ROLL or BLINK, registered
// -----------------------------------------------------------------------------
module dice_display #(
    parameter int NUM_DICE    = 2,
    parameter int ROLL_DIV    = 4,
    parameter int BLINK_TICKS = 8,
    parameter int BLINK_COUNT = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clock_en,
    input  logic                    rolling,
    input  logic                    load,
    input  logic                    flash,
    input  logic [3*NUM_DICE-1:0]   dice,
    output logic [7*NUM_DICE-1:0]   HEX,
    output logic                    busy
);

    // Counter widths: $clog2 of the terminal count, never below one bit.
    localparam int RW = (ROLL_DIV > 1) ? $clog2(ROLL_DIV) : 1;
    localparam logic [RW-1:0] ROLL_LAST = RW'(ROLL_DIV - 1);

    // Parameters outside their legal range stop elaboration.
    if ((NUM_DICE < 1) || (ROLL_DIV < 1) || (BLINK_TICKS < 1) || (BLINK_COUNT < 1)) begin : g_bad_param
        $error("dice_display: parameter out of range");
    end

`ifdef DISPLAY_BLINK_EN
    localparam int TW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int HW = ((2 * BLINK_COUNT) > 1) ? $clog2(2 * BLINK_COUNT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BLINK_TICKS - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(2 * BLINK_COUNT - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROLL  = 2'd1,
        S_SHOW  = 2'd2
`ifdef DISPLAY_BLINK_EN
        ,
        S_BLINK = 2'd3
`endif
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low segment code of a die face; 0 and 7 are blank.
    function automatic logic [6:0] seg_encode(input logic [2:0] v);
        logic [6:0] seg;
        case (v)
            3'd1:    seg = 7'b1111001;
            3'd2:    seg = 7'b0100100;
            3'd3:    seg = 7'b0110000;
            3'd4:    seg = 7'b0011001;
            3'd5:    seg = 7'b0010010;
            3'd6:    seg = 7'b0000010;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Animation face of die k: ((phase + k) mod 6) + 1.
    function automatic logic [2:0] roll_face(input logic [2:0] phase, input int k);
        int s;
        s = (int'(phase) + k) % 6;
        return 3'(s + 1);
    endfunction

    state_t                  state_q, state_d;
    logic [3*NUM_DICE-1:0]   latch_q, latch_d;
    logic [2:0]              phase_q, phase_d;
    logic [RW-1:0]           rcnt_q, rcnt_d;
`ifdef DISPLAY_BLINK_EN
    logic [TW-1:0]           btick_q, btick_d;
    logic [HW-1:0]           bhalf_q, bhalf_d;
`endif
    logic [7*NUM_DICE-1:0]   hex_q, hex_d;
    logic                    busy_q, busy_d;

    // Next-state logic: latch, FSM transitions and animation/blink counters.
    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        phase_d = phase_q;
        rcnt_d  = rcnt_q;
`ifdef DISPLAY_BLINK_EN
        btick_d = btick_q;
        bhalf_d = bhalf_q;
`endif
        if (clock_en) begin
            // load latches in every state; transitions follow the tick priority
            if (load) begin
                latch_d = dice;
            end else begin
                latch_d = latch_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (rolling) begin
                        state_d = S_ROLL;
                        phase_d = 3'd0;
                        rcnt_d  = '0;
                    end else if (load) begin
                        state_d = S_SHOW;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ROLL: begin
                    if (rolling) begin
                        if (rcnt_q == ROLL_LAST) begin
                            rcnt_d  = '0;
                            phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
                        end else begin
                            rcnt_d  = rcnt_q + {{(RW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_d = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (rolling) begin
                        state_d = S_ROLL;
                        phase_d = 3'd0;
                        rcnt_d  = '0;
                    end else if (load) begin
                        state_d = S_SHOW;
`ifdef DISPLAY_BLINK_EN
                    end else if (flash) begin
                        state_d = S_BLINK;
                        btick_d = '0;
                        bhalf_d = '0;
`endif
                    end else begin
                        state_d = S_SHOW;
                    end
                end
`ifdef DISPLAY_BLINK_EN
                S_BLINK: begin
                    if (rolling) begin
                        state_d = S_ROLL;
                        phase_d = 3'd0;
                        rcnt_d  = '0;
                    end else if (!load && flash) begin
                        // restart from the blank half
                        btick_d = '0;
                        bhalf_d = '0;
                    end else if (btick_q == TICK_LAST) begin
                        btick_d = '0;
                        if (bhalf_q == HALF_LAST) begin
                            bhalf_d = '0;
                            state_d = S_SHOW;
                        end else begin
                            bhalf_d = bhalf_q + {{(HW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        btick_d = btick_q + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output decode from the next state so HEX/busy reflect the causing tick.
    always_comb begin
        hex_d  = {(7*NUM_DICE){1'b1}};
        busy_d = 1'b0;
        for (int k = 0; k < NUM_DICE; k++) begin
            case (state_d)
                S_IDLE:  hex_d[7*k +: 7] = SEG_BLANK;
                S_ROLL:  hex_d[7*k +: 7] = seg_encode(roll_face(phase_d, k));
                S_SHOW:  hex_d[7*k +: 7] = seg_encode(latch_d[3*k +: 3]);
`ifdef DISPLAY_BLINK_EN
                // even halves are blank, odd halves visible
                S_BLINK: hex_d[7*k +: 7] = bhalf_d[0] ? seg_encode(latch_d[3*k +: 3]) : SEG_BLANK;
`endif
                default: hex_d[7*k +: 7] = SEG_BLANK;
            endcase
        end
`ifdef DISPLAY_BLINK_EN
        if ((state_d == S_ROLL) || (state_d == S_BLINK)) begin
`else
        if (state_d == S_ROLL) begin
`endif
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // State and output registers; reset wins over clock_en.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            latch_q <= '0;
            phase_q <= 3'd0;
            rcnt_q  <= '0;
`ifdef DISPLAY_BLINK_EN
            btick_q <= '0;
            bhalf_q <= '0;
`endif
            hex_q   <= {(7*NUM_DICE){1'b1}};
            busy_q  <= 1'b0;
        end else if (clock_en) begin
            state_q <= state_d;
            latch_q <= latch_d;
            phase_q <= phase_d;
            rcnt_q  <= rcnt_d;
`ifdef DISPLAY_BLINK_EN
            btick_q <= btick_d;
            bhalf_q <= bhalf_d;
`endif
            hex_q   <= hex_d;
            busy_q  <= busy_d;
        end
    end

    assign HEX  = hex_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_dice_display.sv
module tb_dice_display;

    localparam int ND  = 2;
    localparam int RD  = 4;
    localparam int BT  = 8;
    localparam int BC  = 3;
    localparam int BLEN = 2 * BT * BC;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              clock_en = 1'b0;
    logic              rolling = 1'b0;
    logic              load = 1'b0;
    logic              flash = 1'b0;
    logic [3*ND-1:0]   dice = '0;
    logic [7*ND-1:0]   HEX;
    logic              busy;

    dice_display #(
        .NUM_DICE(ND), .ROLL_DIV(RD), .BLINK_TICKS(BT), .BLINK_COUNT(BC)
    ) dut (
        .clock(clock), .reset(reset), .clock_en(clock_en), .rolling(rolling),
        .load(load), .flash(flash), .dice(dice), .HEX(HEX), .busy(busy)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // expected {HEX, busy} after the next rising edge
    logic [7*ND:0] exp_q[$];

    // reference model: mode 0 idle, 1 roll, 2 show, 3 blink
    int         m_mode = 0;
    int         m_rt = 0;   // ticks spent in ROLL since entry
    int         m_bt = 0;   // ticks spent in BLINK since (re)start
    logic [2:0] m_lat[ND];

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7*ND:0] model_out();
        logic [7*ND-1:0] h;
        logic b;
        h = '1;
        b = (m_mode == 1) || (m_mode == 3);
        for (int k = 0; k < ND; k++) begin
            if (m_mode == 1)
                h[7*k +: 7] = seg_of((((m_rt / RD) % 6) + k) % 6 + 1);
            else if (m_mode == 2)
                h[7*k +: 7] = seg_of(int'(m_lat[k]));
            else if (m_mode == 3)
                h[7*k +: 7] = (((m_bt / BT) % 2) == 1) ? seg_of(int'(m_lat[k])) : 7'b1111111;
            else
                h[7*k +: 7] = 7'b1111111;
        end
        return {h, b};
    endfunction

    task automatic model_step(input logic r, input logic ce, input logic ro,
                              input logic ld, input logic fl, input logic [3*ND-1:0] d);
        bit blink_on;
`ifdef DISPLAY_BLINK_EN
        blink_on = 1'b1;
`else
        blink_on = 1'b0;
`endif
        if (r) begin
            m_mode = 0; m_rt = 0; m_bt = 0;
            for (int k = 0; k < ND; k++) m_lat[k] = 3'd0;
        end else if (ce) begin
            if (ld) for (int k = 0; k < ND; k++) m_lat[k] = d[3*k +: 3];
            case (m_mode)
                0: if (ro) begin m_mode = 1; m_rt = 0; end
                   else if (ld) m_mode = 2;
                1: if (ro) m_rt++;
                   else m_mode = 2;
                2: if (ro) begin m_mode = 1; m_rt = 0; end
                   else if (!ld && fl && blink_on) begin m_mode = 3; m_bt = 0; end
                default: begin
                    if (ro) begin m_mode = 1; m_rt = 0; end
                    else if (!ld && fl) m_bt = 0;
                    else begin
                        m_bt++;
                        if (m_bt == BLEN) m_mode = 2;
                    end
                end
            endcase
        end
    endtask

    // drive one cycle of stimulus and queue the response it should cause
    task automatic tick(input logic r, input logic ce, input logic ro,
                        input logic ld, input logic fl, input logic [3*ND-1:0] d);
        @(negedge clock);
        reset = r; clock_en = ce; rolling = ro; load = ld; flash = fl; dice = d;
        model_step(r, ce, ro, ld, fl, d);
        exp_q.push_back(model_out());
    endtask

    task automatic idle_ticks(input int n, input logic ro);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, ro, 1'b0, 1'b0, '0);
    endtask

    // monitor: compare DUT outputs after every edge that has a queued expectation
    initial begin
        logic [7*ND:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (HEX !== e[7*ND:1]) begin
                    errors++;
                    $display("FAIL hex at %0t: got %b expected %b", $time, HEX, e[7*ND:1]);
                end
                checks++;
                if (busy !== e[0]) begin
                    errors++;
                    $display("FAIL busy at %0t: got %b expected %b", $time, busy, e[0]);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < ND; k++) m_lat[k] = 3'd0;

        // reset state
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle_ticks(2, 1'b0);

        // load {5,2}
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, {3'd5, 3'd2});
        idle_ticks(2, 1'b0);

        // roll animation over a full wrap, load {6,6} mid-roll, then drop rolling
        idle_ticks(26, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, {3'd6, 3'd6});
        idle_ticks(3, 1'b1);
        idle_ticks(2, 1'b0);

        // full blink sequence
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        idle_ticks(BLEN + 4, 1'b0);

        // abort at tick 10 of a blink
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        idle_ticks(9, 1'b0);
        idle_ticks(6, 1'b1);
        idle_ticks(1, 1'b0);

        // restart mid-blink, load during blink
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        idle_ticks(20, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        idle_ticks(12, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, {3'd3, 3'd4});
        idle_ticks(BLEN, 1'b0);

        // invalid values
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, {3'd7, 3'd0});
        idle_ticks(2, 1'b0);

        // reset during ROLL with clock_en low
        idle_ticks(7, 1'b1);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // gating: nothing happens without clock_en
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, {3'd1, 3'd4});
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, {3'd2, 3'd2});
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle_ticks(1, 1'b0);
        // flash in SHOW (ignored when the blink feature is absent)
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        idle_ticks(BT + 2, 1'b0);

        // randomized segments
        for (int s = 0; s < 60; s++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 3);
            len  = $urandom_range(5, 60);
            if (kind == 3) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
            for (int i = 0; i < len; i++) begin
                logic r, ce, ro, ld, fl;
                logic [3*ND-1:0] d;
                r  = ($urandom_range(0, 299) == 0);
                ce = ($urandom_range(0, 7) != 0);
                ro = (kind == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 29) == 0);
                ld = ($urandom_range(0, 15) == 0);
                fl = (kind == 2) ? ($urandom_range(0, 39) == 0) : 1'b0;
                d  = 6'($urandom);
                tick(r, ce, ro, ld, fl, d);
            end
        end

        // let the monitor drain the queue, bounded
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
